// File: rtl/ex_mem_skid_reg.sv
// rtl/ex_mem_skid_reg.sv - Elastic EX/MEM pipeline register with 2-entry skid buffer.
// Optional backpressure stall counter is built when EX_MEM_STAT_EN is defined.
module ex_mem_skid_reg #(
    parameter int             W      = 32,
    parameter logic [W-1:0]   NOP_IR = '0,
    parameter int             STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      ir_e,
    input  logic [W-1:0]      pc8_e,
    input  logic [W-1:0]      alu_e,
    input  logic [W-1:0]      hilo_e,
    input  logic [W-1:0]      rt_e,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      ir_m,
    output logic [W-1:0]      pc8_m,
    output logic [W-1:0]      alu_m,
    output logic [W-1:0]      hilo_m,
    output logic [W-1:0]      rd2_m,
    output logic [STAT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   acc, pop;
    logic   ld_main_in, ld_main_skid, ld_skid, ld_bubble;
    logic [W-1:0] skid_ir, skid_pc8, skid_alu, skid_hilo, skid_rt;

    // Handshake outputs decode the state flops only, so neither ready nor valid
    // has a combinational path from the opposite side of the stage.
    assign out_valid = (state_q != EMPTY);
    assign in_ready  = (state_q != TWO);
    assign acc       = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (acc) state_d = ONE;
                ONE:     if (acc && !pop) state_d = TWO;
                         else if (!acc && pop) state_d = EMPTY;
                TWO:     if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        ld_bubble    = 1'b0;
        if (flush) begin
            ld_bubble = 1'b1;
        end else begin
            case (state_q)
                EMPTY: ld_main_in = acc;
                ONE: begin
                    ld_main_in = acc && pop;
                    ld_skid    = acc && !pop;
                    ld_bubble  = !acc && pop;
                end
                TWO:     ld_main_skid = pop;
                default: ld_bubble    = 1'b1;
            endcase
        end
    end

    // Only ir_m is forced to a bubble; the data fields are qualified by out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_m   <= NOP_IR;
            pc8_m  <= '0;
            alu_m  <= '0;
            hilo_m <= '0;
            rd2_m  <= '0;
        end else if (ld_main_in) begin
            ir_m   <= ir_e;
            pc8_m  <= pc8_e;
            alu_m  <= alu_e;
            hilo_m <= hilo_e;
            rd2_m  <= rt_e;
        end else if (ld_main_skid) begin
            ir_m   <= skid_ir;
            pc8_m  <= skid_pc8;
            alu_m  <= skid_alu;
            hilo_m <= skid_hilo;
            rd2_m  <= skid_rt;
        end else if (ld_bubble) begin
            ir_m   <= NOP_IR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_ir   <= '0;
            skid_pc8  <= '0;
            skid_alu  <= '0;
            skid_hilo <= '0;
            skid_rt   <= '0;
        end else if (ld_skid) begin
            skid_ir   <= ir_e;
            skid_pc8  <= pc8_e;
            skid_alu  <= alu_e;
            skid_hilo <= hilo_e;
            skid_rt   <= rt_e;
        end
    end

`ifdef EX_MEM_STAT_EN
    logic [STAT_W-1:0] stall_q;

    // Saturating count of cycles MEM refused a valid entry; flush does not clear it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_q <= '0;
        else if (out_valid && !out_ready && (stall_q != {STAT_W{1'b1}}))
            stall_q <= stall_q + STAT_W'(1);
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb/tb_ex_mem_skid_reg.sv - Self-checking bench for ex_mem_skid_reg (vectors, corner cases, random vs queue model).
module tb_ex_mem_skid_reg;

    localparam int W      = 32;
    localparam int STAT_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [W-1:0]      ir_e = '0, pc8_e = '0, alu_e = '0, hilo_e = '0, rt_e = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [W-1:0]      ir_m, pc8_m, alu_m, hilo_m, rd2_m;
    logic [STAT_W-1:0] stall_cnt;

    ex_mem_skid_reg #(.W(W), .NOP_IR('0), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ir_e(ir_e), .pc8_e(pc8_e), .alu_e(alu_e), .hilo_e(hilo_e), .rt_e(rt_e),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .ir_m(ir_m), .pc8_m(pc8_m), .alu_m(alu_m), .hilo_m(hilo_m), .rd2_m(rd2_m),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ir;
        logic        ordy;
        logic        fl;
        logic        e_ov;
        logic [31:0] e_ir;
        logic        e_ird;
    } vec_t;

    typedef struct {
        logic [31:0] ir, pc8, alu, hilo, rt;
    } entry_t;

    vec_t   vecs[$];
    entry_t q[$];
    entry_t last;
    int     exp_stall;

    task automatic add(input logic iv, input logic [31:0] ir, input logic ordy, input logic fl,
                       input logic e_ov, input logic [31:0] e_ir, input logic e_ird);
        vec_t v;
        v.iv = iv; v.ir = ir; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_ird = e_ird;
        vecs.push_back(v);
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic drive(input logic iv, input logic [31:0] ir, input logic ordy, input logic fl);
        in_valid = iv; ir_e = ir; pc8_e = ir ^ 32'h1000; alu_e = ir + 1;
        hilo_e = ~ir; rt_e = ir << 1; out_ready = ordy; flush = fl;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Stream
        add(1, 32'h8C010004, 1, 0, 1, 32'h8C010004, 1);
        add(1, 32'h00221820, 1, 0, 1, 32'h00221820, 1);
        add(1, 32'hAC030008, 1, 0, 1, 32'hAC030008, 1);
        add(0, 32'h0,        1, 0, 0, 32'h0,        1);
        // Backpressure: A held, B to skid, C refused then resent
        add(1, 32'h11, 0, 0, 1, 32'h11, 1);
        add(1, 32'h22, 0, 0, 1, 32'h11, 0);
        add(1, 32'h33, 0, 0, 1, 32'h11, 0);
        add(1, 32'h33, 1, 0, 1, 32'h22, 1);
        add(1, 32'h33, 1, 0, 1, 32'h33, 1);
        add(0, 32'h0,  1, 0, 0, 32'h0,  1);
        // Flush in TWO
        add(1, 32'h77, 0, 0, 1, 32'h77, 1);
        add(1, 32'h88, 0, 0, 1, 32'h77, 0);
        add(1, 32'h44, 0, 1, 0, 32'h0,  1);
        add(0, 32'h0,  1, 0, 0, 32'h0,  1);
        // Flush drops an input accepted in the same cycle
        add(1, 32'h99, 0, 0, 1, 32'h99, 1);
        add(1, 32'hAA, 1, 1, 0, 32'h0,  1);
        add(0, 32'h0,  1, 0, 0, 32'h0,  1);
        // Simultaneous accept and pop in ONE
        add(1, 32'h55, 0, 0, 1, 32'h55, 1);
        add(1, 32'h66, 1, 0, 1, 32'h66, 1);
        add(0, 32'h0,  1, 0, 0, 32'h0,  1);

        @(negedge clk);
        do_reset();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready",  32'(in_ready),  32'd1);
        chk("reset_ir_m",      ir_m,  32'h0);
        chk("reset_pc8_m",     pc8_m, 32'h0);
        chk("reset_rd2_m",     rd2_m, 32'h0);
        chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].ir, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
            chk($sformatf("vec%0d_ir_m", i),      ir_m,           vecs[i].e_ir);
            chk($sformatf("vec%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].e_ird));
        end
        chk("pc8_after_acc_pop", pc8_m, 32'h66 ^ 32'h1000);
        chk("rd2_after_acc_pop", rd2_m, 32'h66 << 1);

        // Asynchronous reset with two entries held, checked before the next edge
        drive(1, 32'hDEAD0001, 0, 0);
        drive(1, 32'hDEAD0002, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_in_ready",  32'(in_ready),  32'd1);
        chk("async_rst_ir_m",      ir_m,   32'h0);
        chk("async_rst_alu_m",     alu_m,  32'h0);
        chk("async_rst_hilo_m",    hilo_m, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 32'h0, 1, 0);
        chk("post_rst_skid_empty", 32'(out_valid), 32'd0);

        // Stall counter saturation
        do_reset();
        drive(1, 32'h1234, 0, 0);
        for (int k = 0; k < 20; k++) drive(0, 32'h0, 0, 0);
`ifdef EX_MEM_STAT_EN
        chk("stall_saturated", 32'(stall_cnt), 32'd15);
`else
        chk("stall_disabled",  32'(stall_cnt), 32'd0);
`endif
        drive(0, 32'h0, 0, 1);
`ifdef EX_MEM_STAT_EN
        chk("stall_kept_by_flush", 32'(stall_cnt), 32'd15);
`else
        chk("stall_disabled_flush", 32'(stall_cnt), 32'd0);
`endif

        // Random traffic against a FIFO-of-depth-2 model
        do_reset();
        q.delete();
        last = '{default: '0};
        exp_stall = 0;
        for (int c = 0; c < 400; c++) begin
            entry_t e;
            logic   iv, ordy, fl, m_ov, m_ird;
            e.ir = $urandom; e.pc8 = $urandom; e.alu = $urandom; e.hilo = $urandom; e.rt = $urandom;
            iv   = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 6);
            fl   = ($urandom_range(0, 15) == 0);
            m_ov  = (q.size() > 0);
            m_ird = (q.size() < 2);
            in_valid = iv; out_ready = ordy; flush = fl;
            ir_e = e.ir; pc8_e = e.pc8; alu_e = e.alu; hilo_e = e.hilo; rt_e = e.rt;
            @(posedge clk);
            if (fl) begin
                q.delete();
            end else begin
                if (m_ov && ordy) void'(q.pop_front());
                if (iv && m_ird) q.push_back(e);
            end
`ifdef EX_MEM_STAT_EN
            if (m_ov && !ordy && exp_stall < (1 << STAT_W) - 1) exp_stall++;
`endif
            if (q.size() > 0) last = q[0];
            @(negedge clk);
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("rnd_in_ready",  32'(in_ready),  32'(q.size() < 2));
            chk("rnd_ir_m",      ir_m, (q.size() > 0) ? q[0].ir : 32'h0);
            chk("rnd_pc8_m",     pc8_m,  last.pc8);
            chk("rnd_alu_m",     alu_m,  last.alu);
            chk("rnd_hilo_m",    hilo_m, last.hilo);
            chk("rnd_rd2_m",     rd2_m,  last.rt);
            chk("rnd_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
